// File: rtl/uop_rom_seq.sv
// Writable micro-op table with a burst sequencer: streams req_len+1 consecutive
// entries from req_addr over a valid/ready interface, one per cycle.
//
// state | meaning
// IDLE  | waiting for a burst request; req_ready high
// READ  | loading table entries into Uop as the consumer allows
// DRAIN | final entry presented, waiting for its handshake
module uop_rom_seq #(
    parameter int              DW          = 8,
    parameter int              DEPTH       = 256,
    parameter int              AW          = $clog2(DEPTH),  // derived from DEPTH; leave at default
    parameter logic [DW-1:0]   DEFAULT_UOP = 8'h02
) (
    input  logic          CS,
    input  logic          cen,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    output logic [DW-1:0] Uop,
    output logic          uop_valid,
    input  logic          uop_ready,
    output logic          uop_last,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] rem;
    logic [DW-1:0] tbl [DEPTH];

    // Table write port; reads below see the pre-write contents on the same edge.
    always_ff @(posedge CS or posedge cen) begin
        if (cen) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= (i == 0) ? '0 : DEFAULT_UOP;
            end
        end else if (wr_en) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CS or posedge cen) begin
        if (cen) begin
            state     <= IDLE;
            ptr       <= '0;
            rem       <= '0;
            Uop       <= '0;
            uop_valid <= 1'b0;
            uop_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ptr   <= req_addr;
                        rem   <= req_len;
                        state <= READ;
                    end
                end
                READ: begin
                    // Advance only when the output register is empty or being consumed.
                    if (!uop_valid || uop_ready) begin
                        Uop       <= tbl[ptr];
                        uop_valid <= 1'b1;
                        uop_last  <= (rem == '0);
                        ptr       <= ptr + AW'(1);
                        rem       <= rem - AW'(1);
                        if (rem == '0) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (uop_ready) begin
                        uop_valid <= 1'b0;
                        uop_last  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: doc/uop_rom_seq.md
Name: uop_rom_seq

Overview:
- Parametrised, writable micro-op ROM with a burst sequencer for the speech-processor control path.
- Accepts a start address and length, then streams consecutive micro-ops over a valid/ready interface. Throughput is one per cycle, with backpressure.
- Table resets to the standard default image: entry 0 = 0, all others = DEFAULT_UOP. Firmware may patch entries at runtime through a write port.
- Successor to the fixed 256x8 single-lookup micro-op ROM.

Parameters:
DW, 8, micro-op width in bits
DEPTH, 256, table entries; power of two, >= 4
AW, clog2(DEPTH), address/length width (derived; not overridden)
DEFAULT_UOP, 8'h02, reset value of entries 1..DEPTH-1 (entry 0 resets to 0)

Ports:
CS  input  1  clock; all state updates on rising edge
cen  input  1  asynchronous active-high reset
wr_en  input  1  table write strobe; honoured in any state
wr_addr  input  AW  table write address
wr_data  input  DW  table write data
req_valid  input  1  burst request valid
req_ready  output  1  burst request accepted when high with req_valid
req_addr  input  AW  first table address of burst
req_len  input  AW  burst length minus one (0 = 1 uop, DEPTH-1 = full table)
Uop  output  DW  registered micro-op
uop_valid  output  1  Uop valid
uop_ready  input  1  consumer accepts Uop
uop_last  output  1  Uop is final entry of burst
busy  output  1  high in READ or DRAIN

Behaviour:
- Reset (cen=1, asynchronous): table restored to the default image; state IDLE; internal pointer and remaining count cleared.
  - Outputs during and after reset: Uop=0, uop_valid=0, uop_last=0, req_ready=1, busy=0.
  - Reset mid-burst aborts immediately. No partial output survives.
- States: IDLE, READ, DRAIN.
  - req_ready = (state==IDLE). busy = !IDLE.
- IDLE:
  - On req_valid&&req_ready: ptr<=req_addr, rem<=req_len, go READ.
  - Uop, uop_valid and uop_last hold their last values; uop_valid is 0 in IDLE.
- READ, load condition: load when (!uop_valid || uop_ready). On a load:
  - Uop<=table[ptr], uop_valid<=1, uop_last<=(rem==0).
  - ptr<=ptr+1, wrapping modulo DEPTH (DEPTH-1 -> 0).
  - rem<=rem-1.
  - If rem==0, go DRAIN.
- READ, stalled (uop_valid && !uop_ready): Uop, uop_last, ptr and rem are all held stable.
- DRAIN:
  - On uop_ready: uop_valid<=0, uop_last<=0, go IDLE.
  - Otherwise hold.
- Latency and throughput:
  - Request accepted at edge N; first Uop valid after edge N+1.
  - With uop_ready held high, one uop per cycle; a burst of L uops completes its last handshake at edge N+L+1.
  - req_ready returns high the cycle after the final handshake.
- Writes:
  - table[wr_addr]<=wr_data on any edge with wr_en, in all states.
  - Same-cycle write and read of the same address: the read returns the old contents.
  - A write to an entry not yet streamed in the current burst is visible when that entry is read.
- Arithmetic: ptr and rem are AW bits; wrap is natural modulo 2^AW. A length of DEPTH streams every entry exactly once, starting at req_addr.
- req_valid outside IDLE is ignored; there is no queuing.
- uop_ready while uop_valid=0 has no effect.

Test Plan:
- Reset, then request addr=0, len=2, uop_ready=1 -> Uop sequence 0x00, 0x02, 0x02; uop_last on the 3rd only; req_ready=1 one cycle after.
- Write table[5]=0xA5 and table[6]=0x3C, then burst addr=4, len=3 -> 0x02, 0xA5, 0x3C, 0x02.
- Burst addr=DEPTH-2=254, len=3 -> addresses 254, 255, 0, 1 -> 0x02, 0x02, 0x00, 0x02; wrap is correct.
- Burst addr=8, len=4 with uop_ready toggled 1,0,0,1,1,0,1… -> Uop and uop_last held stable while stalled; no entry skipped or duplicated; exactly 5 handshakes.
- Same-cycle write table[10]=0x77 on the edge that loads entry 10 -> 0x02 output; re-burst of addr 10 -> 0x77.
- Assert cen during the 3rd uop of an 8-uop burst -> uop_valid=0, Uop=0 and busy=0 immediately; table[5] reads back 0x02 afterwards; a new request is accepted after cen falls.
